// File: rtl/sys_pll_rst_ctrl_pkg.sv
// ============================================================================
// Module   : sys_pll_rst_ctrl_pkg
// Brief    : State encoding and 27 MHz default timing for the PLL reset control.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sys_pll_rst_ctrl_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int RESET_CYCLES     = 16;
  localparam int LOCK_TIMEOUT_1MS = 27000;
  localparam int STABLE_100US     = 2700;

endpackage

`default_nettype wire

// File: rtl/sys_pll_rst_ctrl_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic 1-bit two-flop synchroniser, async active-high reset to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_pll_rst_ctrl.sv
// ============================================================================
// Module   : sys_pll_rst_ctrl
// Brief    : PLL lock handshake: pulses PLL reset, retries on timeout and
//            releases core reset once lock has been stable long enough.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sys_pll_rst_ctrl #(
  parameter int RESET_CYCLES  = sys_pll_rst_ctrl_pkg::RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = sys_pll_rst_ctrl_pkg::LOCK_TIMEOUT_1MS,
  parameter int STABLE_CYCLES = sys_pll_rst_ctrl_pkg::STABLE_100US,
  parameter int CNT_W         = 16,
  parameter int RETRY_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pll_locked,
  output logic               pll_reset,
  output logic               core_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  import sys_pll_rst_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               lk_s;
  logic               retry_inc;
  logic               lost_set;
  logic               cnt_clr;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    case (state)
      PLL_RST: begin
        if (enable && (cnt == RST_LAST)) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (!enable) begin
          state_nxt = PLL_RST;
        end else if (lk_s) begin
          state_nxt = STABLE;
        end else if (cnt == TO_LAST) begin
          state_nxt = PLL_RST;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!enable)                  state_nxt = PLL_RST;
        else if (!lk_s)               state_nxt = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = PLL_RST;
        end else if (!lk_s) begin
          state_nxt = WAIT_LOCK;
          lost_set  = 1'b1;
        end
      end
      default: state_nxt = PLL_RST;
    endcase
  end

  // A disabled controller parks in PLL_RST with the counter pinned at zero,
  // so re-enabling always yields a full-length PLL reset pulse.
  assign cnt_clr = (state_nxt != state) || ((state == PLL_RST) && !enable);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PLL_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      core_rst  <= 1'b1;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_clr ? '0 : cnt + 1'b1;
      pll_reset <= (state_nxt == PLL_RST);
      core_rst  <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      lock_lost <= lock_lost | lost_set;
      if (retry_inc && (retry_cnt != '1)) retry_cnt <= retry_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sys_pll_rst_ctrl.sv
// ============================================================================
// Module   : tb_sys_pll_rst_ctrl
// Brief    : Directed self-checking bench for sys_pll_rst_ctrl (small timing).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sys_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pll_locked;
  logic       pll_reset;
  logic       core_rst;
  logic       ready;
  logic       lock_lost;
  logic [1:0] retry_cnt;

  int tests = 0;
  int fails = 0;
  int n     = 0;

  sys_pll_rst_ctrl #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .CNT_W         (8),
    .RETRY_W       (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pll_locked (pll_locked),
    .pll_reset  (pll_reset),
    .core_rst   (core_rst),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Observed vector: {pll_reset, core_rst, ready, lock_lost, retry_cnt[1:0]}
  function automatic logic [5:0] obs();
    return {pll_reset, core_rst, ready, lock_lost, retry_cnt};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s (edge %0d): got %b expected %b", tag, n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_to(input int k);
    while (n < k) tick();
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    pll_locked = 1'b0;
    #1;
    check("async_reset_vals", obs(), 6'b110000);
    repeat (2) @(posedge clk);
    #1;
    n   = 0;
    rst = 1'b0;
    check("reset_vals_edge0", obs(), 6'b110000);

    // PLL reset pulse length
    wait_to(3);  check("pll_rst_edge3",  obs(), 6'b110000);
    wait_to(4);  check("wait_lock_edge4", obs(), 6'b010000);

    // Lock before edge 10 -> STABLE at 12 -> RUN at 20
    wait_to(9);  pll_locked = 1'b1;
    wait_to(19); check("stable_edge19", obs(), 6'b010000);
    wait_to(20); check("run_edge20",    obs(), 6'b001000);

    // Lock loss before edge 26 -> core_rst at 28
    wait_to(25); pll_locked = 1'b0;
    wait_to(27); check("run_still_edge27", obs(), 6'b001000);
    wait_to(28); check("lost_edge28",      obs(), 6'b010100);
    wait_to(29); pll_locked = 1'b1;
    wait_to(39); check("relock_edge39", obs(), 6'b010100);
    wait_to(40); check("rerun_edge40",  obs(), 6'b001100);

    // Disable in RUN, hold, then re-enable
    enable = 1'b0;
    wait_to(41); check("disable_edge41", obs(), 6'b110100);
    wait_to(45); check("disabled_hold",  obs(), 6'b110100);
    enable = 1'b1;
    wait_to(48); check("reen_pll_rst_edge48", obs(), 6'b110100);
    wait_to(49); check("reen_wait_edge49",    obs(), 6'b010100);

    // STABLE from edge 50; lock dips for 3 cycles at counter=5
    wait_to(55); pll_locked = 1'b0;
    wait_to(58); check("dip_no_run_edge58", obs(), 6'b010100);
    pll_locked = 1'b1;
    wait_to(68); check("dip_restable_edge68", obs(), 6'b010100);
    wait_to(69); check("dip_run_edge69",      obs(), 6'b001100);

    // Lock loss then repeated timeouts with saturating retry count
    pll_locked = 1'b0;
    wait_to(72);  check("lost2_edge72",     obs(), 6'b010100);
    wait_to(91);  check("pre_timeout1",     obs(), 6'b010100);
    wait_to(92);  check("timeout1_edge92",  obs(), 6'b110101);
    wait_to(95);  check("retry_rst_edge95", obs(), 6'b110101);
    wait_to(96);  check("retry_wait_edge96", obs(), 6'b010101);
    wait_to(116); check("timeout2_edge116", obs(), 6'b110110);
    wait_to(140); check("timeout3_edge140", obs(), 6'b110111);
    wait_to(164); check("timeout4_sat",     obs(), 6'b110111);

    // Lock and timeout coincide at edge 188 -> STABLE wins
    wait_to(185); pll_locked = 1'b1;
    wait_to(187); check("pre_coincide", obs(), 6'b010111);
    wait_to(188); check("coincide_stable_edge188", obs(), 6'b010111);
    wait_to(196); check("coincide_run_edge196",    obs(), 6'b001111);

    // Mid-STABLE asynchronous reset
    pll_locked = 1'b0;
    wait_to(199); check("lost3_edge199", obs(), 6'b010111);
    pll_locked = 1'b1;
    wait_to(205);
    rst = 1'b1;
    #1;
    check("async_rst_mid_stable", obs(), 6'b110000);
    tick();
    check("rst_held", obs(), 6'b110000);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
